// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW onto a word-addressed memory,
// with read-modify-write for sub-word stores. Optional macro: LSU_ALIGN_CHECK_EN.
module lsu_mem_ctrl #(
    parameter int MEM_WORDS = 32,
    parameter int IDX_W     = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state_reg;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic        uns_reg;
    logic [1:0]  off_reg;
    logic [15:0] wdata_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;
    logic        done_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;

    logic        mis_in;
    logic [7:0]  lane_b [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [3:0]  be;
    logic [31:0] merged;
    logic        unused_bits;

`ifdef LSU_ALIGN_CHECK_EN
    assign mis_in = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
    // Offending low bits are simply ignored by lane selection below.
    assign mis_in = 1'b0;
`endif

    assign unused_bits = ^addr[31:IDX_W+2];

    // Per-byte lane view of the read word and the RMW merge of the store lanes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_b[gi] = mem_rdata[8*gi +: 8];
            assign be[gi] = (size_reg == 2'b00) ? (off_reg == LANE) : (off_reg[1] == LANE[1]);
            assign merged[8*gi +: 8] = !be[gi] ? mem_rdata[8*gi +: 8] :
                                       ((size_reg == 2'b01) && LANE[0]) ? wdata_reg[15:8] :
                                       wdata_reg[7:0];
        end
    endgenerate

    assign byte_sel = lane_b[off_reg];
    assign half_sel = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_val = mem_rdata;
        case (size_reg)
            2'b00:   load_val = {{24{~uns_reg & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{~uns_reg & half_sel[15]}}, half_sel};
            default: load_val = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            we_reg        <= 1'b0;
            size_reg      <= 2'b00;
            uns_reg       <= 1'b0;
            off_reg       <= 2'b00;
            wdata_reg     <= 16'h0;
            rdata_reg     <= 32'h0;
            err_reg       <= 1'b0;
            done_reg      <= 1'b0;
            mem_addr_reg  <= 32'h0;
            mem_wdata_reg <= 32'h0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        we_reg        <= we;
                        size_reg      <= size;
                        uns_reg       <= uns;
                        off_reg       <= addr[1:0];
                        wdata_reg     <= wdata[15:0];
                        mem_addr_reg  <= {{(32-IDX_W){1'b0}}, addr[IDX_W+1:2]};
                        mem_wdata_reg <= wdata;
                        if (mis_in) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            err_reg   <= 1'b1;
                            rdata_reg <= 32'h0;
                        end else if (!we) begin
                            state_reg <= RD;
                        end else if (size[1]) begin
                            state_reg <= WR;
                        end else begin
                            state_reg <= RD;
                        end
                    end
                end
                RD: begin
                    if (!we_reg) begin
                        rdata_reg <= load_val;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        mem_wdata_reg <= merged;
                        state_reg     <= WR;
                    end
                end
                WR: begin
                    done_reg  <= 1'b1;
                    state_reg <= DONE;
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ready     = (state_reg == IDLE);
    assign done      = done_reg;
    assign err       = err_reg;
    assign rdata     = rdata_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    // Gated by rst_n so a reset landing on WR can never commit a half-built RMW word.
    assign mem_we    = (state_reg == WR) & rst_n;

endmodule
